// File: rtl/pwm_driver_pkg.sv
// Shared definitions for the motor PWM driver.
//   state_e        : driver state encoding (IDLE, RUN, DEAD)
//   PWM_PERIOD_MAX : last period count before wrap (a period is 255 ticks)
package pwm_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  localparam logic [7:0] PWM_PERIOD_MAX = 8'd254;

endpackage

// File: rtl/pwm_driver_tick_gen.sv
// Prescaler plus 8-bit period counter for the PWM driver.
//   clock, reset_n : clock, async active-low reset
//   enable         : counts while high, both counters held at 0 while low
//   tick           : one cycle per PRESCALE clocks (prescaler at PRESCALE-1)
//   period_cnt     : 0..PWM_PERIOD_MAX, advances on tick
//   boundary       : tick at period_cnt == PWM_PERIOD_MAX (end of period)
module pwm_tick_gen
  import pwm_driver_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic       tick,
  output logic       boundary,
  output logic [7:0] period_cnt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_nxt;
  logic [7:0]    cnt_nxt;

  assign tick       = enable && (presc_q == PW'(PRESCALE - 1));
  assign boundary   = tick && (period_cnt == PWM_PERIOD_MAX);

  always_comb begin
    presc_nxt = '0;
    cnt_nxt   = '0;
    if (enable) begin
      presc_nxt = tick ? '0 : presc_q + PW'(1);
      if (boundary)  cnt_nxt = '0;
      else if (tick) cnt_nxt = period_cnt + 8'd1;
      else           cnt_nxt = period_cnt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      period_cnt <= '0;
    end else begin
      presc_q    <= presc_nxt;
      period_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/pwm_driver.sv
// Motor PWM / direction pin driver with double-buffered settings.
// Requests are buffered and applied on PWM period boundaries; a direction
// reversal first runs DEAD_PERIODS full periods of forced-low output.
//   clock, reset_n : clock, async active-low reset
//   pwm_enable     : level, enables the output stage (low = IDLE)
//   pwm_update     : one-cycle load strobe for pwm_ratio / pwm_direction
//   pwm_ratio      : high time out of 255 ticks
//   pwm_direction  : requested direction
//   pwm_done       : one-cycle pulse when the new setting reaches the pins
//   pwm_out        : PWM pin (registered)
//   dir_out        : direction pin (registered)
//   busy           : request pending or dead-time running
module pwm_driver
  import pwm_driver_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out,
  output logic       busy
);

  localparam int DW = $clog2(DEAD_PERIODS + 1);

  state_e        state_q, state_nxt;
  logic          pend_q, pend_nxt;
  logic [7:0]    pend_ratio_q;
  logic          pend_dir_q;
  logic [7:0]    ratio_q, ratio_nxt;
  logic          dir_nxt;
  logic [DW-1:0] dead_q, dead_nxt;
  logic          apply;
  logic          pwm_nxt;

  logic          tick, boundary;
  logic [7:0]    period_cnt, cnt_nxt;

  // effective request: a strobe in this cycle is captured first, so it can
  // be applied at a coincident boundary and overrides the buffered values
  logic          eff_pend, eff_dir;
  logic [7:0]    eff_ratio;

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (pwm_enable),
    .tick       (tick),
    .boundary   (boundary),
    .period_cnt (period_cnt)
  );

  assign eff_pend  = pend_q | pwm_update;
  assign eff_ratio = pwm_update ? pwm_ratio     : pend_ratio_q;
  assign eff_dir   = pwm_update ? pwm_direction : pend_dir_q;

  // next period count, mirrored here so pwm_out can be registered in
  // step with the counter instead of lagging it by a cycle
  always_comb begin
    cnt_nxt = '0;
    if (pwm_enable) begin
      if (boundary)  cnt_nxt = '0;
      else if (tick) cnt_nxt = period_cnt + 8'd1;
      else           cnt_nxt = period_cnt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    dead_nxt  = dead_q;
    apply     = 1'b0;
    if (!pwm_enable) begin
      // disabled: no dead-time needed since the PWM pin is held low
      state_nxt = ST_IDLE;
      dead_nxt  = '0;
      apply     = eff_pend;
    end else begin
      unique case (state_q)
        ST_IDLE: state_nxt = ST_RUN;
        ST_RUN: begin
          if (boundary && eff_pend) begin
            if (eff_dir == dir_out) begin
              apply = 1'b1;
            end else begin
              state_nxt = ST_DEAD;
              dead_nxt  = DW'(DEAD_PERIODS);
            end
          end
        end
        ST_DEAD: begin
          if (boundary) begin
            if (dead_q <= DW'(1)) begin
              // latest pending values win, whatever their direction
              apply     = eff_pend;
              state_nxt = ST_RUN;
              dead_nxt  = '0;
            end else begin
              dead_nxt  = dead_q - DW'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign pend_nxt  = apply ? 1'b0      : eff_pend;
  assign ratio_nxt = apply ? eff_ratio : ratio_q;
  assign dir_nxt   = apply ? eff_dir   : dir_out;
  assign pwm_nxt   = (state_nxt == ST_RUN) && (cnt_nxt < ratio_nxt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pend_q       <= 1'b0;
      pend_ratio_q <= '0;
      pend_dir_q   <= 1'b0;
      ratio_q      <= '0;
      dir_out      <= 1'b0;
      dead_q       <= '0;
      pwm_done     <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      pend_q   <= pend_nxt;
      ratio_q  <= ratio_nxt;
      dir_out  <= dir_nxt;
      dead_q   <= dead_nxt;
      pwm_done <= apply;
      pwm_out  <= pwm_nxt;
      if (pwm_update) begin
        pend_ratio_q <= pwm_ratio;
        pend_dir_q   <= pwm_direction;
      end
    end
  end

  assign busy = pend_q || (state_q == ST_DEAD);

endmodule

// File: tb/tb_pwm_driver.sv
// Directed bench for pwm_driver (PRESCALE=4, DEAD_PERIODS=2: period = 1020 clocks).
module tb_pwm_driver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pwm_enable, pwm_update, pwm_direction;
  logic [7:0] pwm_ratio;
  logic       pwm_done, pwm_out, dir_out, busy;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int done_cnt = 0;
  int overlap  = 0;
  logic prev_dir = 1'b0, prev_pwm = 1'b0;

  pwm_driver #(.PRESCALE(4), .DEAD_PERIODS(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pwm_enable    (pwm_enable),
    .pwm_update    (pwm_update),
    .pwm_ratio     (pwm_ratio),
    .pwm_direction (pwm_direction),
    .pwm_done      (pwm_done),
    .pwm_out       (pwm_out),
    .dir_out       (dir_out),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // done pulse counter and H-bridge overlap watch (pin high under old dir
  // in the cycle right before a direction change)
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (pwm_done === 1'b1) done_cnt++;
      if ((dir_out !== prev_dir) && (prev_pwm === 1'b1)) overlap++;
    end
    prev_dir = dir_out;
    prev_pwm = pwm_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic upd(input logic [7:0] r, input logic d);
    pwm_update    = 1'b1;
    pwm_ratio     = r;
    pwm_direction = d;
    step(1);
    pwm_update    = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (pwm_done !== 1'b1 && n < max) begin
      step(1);
      n++;
    end
  endtask

  // samples n cycles; hi_a counts pwm_out highs in the first `split`, hi_b after
  task automatic measure(input int n, input int split, output int hi_a, output int hi_b);
    hi_a = 0;
    hi_b = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm_out === 1'b1) begin
        if (i < split) hi_a++;
        else           hi_b++;
      end
      step(1);
    end
  endtask

  initial begin
    int n, ha, hb, snap, sum;
    reset_n = 1'b0; pwm_enable = 1'b0; pwm_update = 1'b0;
    pwm_ratio = '0; pwm_direction = 1'b0;
    #1;
    chk("rst_done", pwm_done, 0);
    chk("rst_pwm",  pwm_out,  0);
    chk("rst_dir",  dir_out,  0);
    chk("rst_busy", busy,     0);
    step(3);
    reset_n = 1'b1;
    step(6);

    // IDLE: applied one cycle after capture, no dead-time
    upd(8'h80, 1'b1);
    chk("idle_done", pwm_done, 1);
    chk("idle_dir",  dir_out,  1);
    chk("idle_pwm",  pwm_out,  0);
    chk("idle_busy", busy,     0);
    step(1);
    chk("idle_done_1cyc", pwm_done, 0);

    // RUN same direction: ratio 64, applied at the first boundary
    pwm_enable = 1'b1;
    upd(8'd64, 1'b1);
    chk("run_busy", busy, 1);
    wait_done(1100, n);
    chk("run_latency", n, 1019);
    chk("run_dir", dir_out, 1);
    measure(1020, 256, ha, hb);
    chk("r64_p1_high", ha, 256);
    chk("r64_p1_low",  hb, 0);
    measure(1020, 256, ha, hb);
    chk("r64_p2_high", ha, 256);
    chk("r64_p2_low",  hb, 0);

    // ratio 0 and 255 extremes across 3 periods
    upd(8'd0, 1'b1);
    wait_done(1100, n);
    chk("r0_latency", n, 1019);
    sum = 0;
    for (int p = 0; p < 3; p++) begin
      measure(1020, 1020, ha, hb);
      sum += ha;
    end
    chk("r0_const_low", sum, 0);
    upd(8'd255, 1'b1);
    wait_done(1100, n);
    chk("r255_latency", n, 1019);
    sum = 0;
    for (int p = 0; p < 3; p++) begin
      measure(1020, 1020, ha, hb);
      sum += ha;
    end
    chk("r255_const_high", sum, 3060);

    // reversal 1 -> 0 with ratio 100: two forced-low periods
    snap = done_cnt;
    upd(8'd100, 1'b0);
    step(1019);
    chk("rev_dead_pwm",  pwm_out,  0);
    chk("rev_dead_busy", busy,     1);
    chk("rev_dead_dir",  dir_out,  1);
    chk("rev_dead_done", pwm_done, 0);
    measure(2040, 2040, ha, hb);
    chk("rev_dead_low", ha, 0);
    chk("rev_done", pwm_done, 1);
    chk("rev_dir",  dir_out,  0);
    chk("rev_pwm",  pwm_out,  1);
    chk("rev_busy", busy,     0);
    measure(1020, 400, ha, hb);
    chk("r100_high", ha, 400);
    chk("r100_low",  hb, 0);
    chk("rev_one_done", done_cnt - snap, 1);
    chk("rev_no_overlap", overlap, 0);

    // three back-to-back updates: one done, last ratio wins
    snap = done_cnt;
    upd(8'd10, 1'b0);
    upd(8'd20, 1'b0);
    upd(8'd30, 1'b0);
    wait_done(1100, n);
    chk("b2b_latency", n, 1017);
    measure(1020, 120, ha, hb);
    chk("b2b_r30_high", ha, 120);
    chk("b2b_r30_low",  hb, 0);
    chk("b2b_one_done", done_cnt - snap, 1);

    // reset pulse in the middle of dead-time
    upd(8'd50, 1'b1);
    step(1029);
    chk("dead_busy", busy, 1);
    snap = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy,     0);
    chk("mid_rst_pwm",  pwm_out,  0);
    chk("mid_rst_dir",  dir_out,  0);
    chk("mid_rst_done", pwm_done, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(20);
    chk("post_rst_no_done", done_cnt - snap, 0);
    chk("post_rst_pwm",  pwm_out, 0);
    chk("post_rst_dir",  dir_out, 0);
    chk("post_rst_busy", busy,    0);

    // enable dropped with a reversal pending: applied as in IDLE
    upd(8'd70, 1'b1);
    step(5);
    chk("drop_pend_busy", busy,     1);
    chk("drop_pend_done", pwm_done, 0);
    snap = done_cnt;
    pwm_enable = 1'b0;
    step(1);
    chk("drop_done", pwm_done, 1);
    chk("drop_dir",  dir_out,  1);
    chk("drop_pwm",  pwm_out,  0);
    chk("drop_busy", busy,     0);
    step(1);
    chk("drop_done_1cyc", pwm_done, 0);
    chk("drop_one_done", done_cnt - snap, 1);
    chk("final_no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_driver.md
# pwm_driver

Generates the physical motor PWM and direction pins from the ratio/direction requests issued by the angle-to-PWM controller. It sits directly downstream of the PWM control stage, consuming `pwm_ratio`/`pwm_direction`/`pwm_update` and returning the one-cycle `pwm_done` acknowledge. New settings are double-buffered and applied only on PWM period boundaries. Direction reversals insert a dead-time of forced-low periods to protect the H-bridge.

## Interface
- `PRESCALE`, default 4: clock cycles per PWM tick; legal range ≥1.
- `DEAD_PERIODS`, default 2: full PWM periods of forced-low output on a direction reversal; legal range ≥1.
- `clock`  in  1  main clock.
- `reset_n`  in  1  reset; one clock, asynchronous, active-low.
- `pwm_enable`  in  1  level; enables the output stage.
- `pwm_update`  in  1  one-cycle request to load `pwm_ratio` and `pwm_direction`.
- `pwm_ratio`  in  8  high-time out of 255; sampled only when `pwm_update`=1.
- `pwm_direction`  in  1  requested direction; sampled only when `pwm_update`=1.
- `pwm_done`  out  1  one-cycle pulse: the requested setting is now driving the pins.
- `pwm_out`  out  1  PWM pin.
- `dir_out`  out  1  direction pin.
- `busy`  out  1  high while a request is pending or dead-time is running.

## Operation
- Reset values: all outputs 0; active ratio 0; active direction 0; pending flag 0; all counters 0; state IDLE.
- Prescaler:
  - counts 0..PRESCALE-1 while `pwm_enable`=1.
  - `tick` is asserted when the prescaler is at PRESCALE-1.
- Period counter: 8 bits, counts 0..254 on `tick`, then wraps to 0. A period is 255 ticks. The boundary is the `tick` at which the count is 254.
- `pwm_out` = (period_cnt < active_ratio) while in RUN.
  - ratio 0 gives constant low.
  - ratio 255 gives constant high.
- Request capture:
  - `pwm_update` loads the pending ratio/direction and sets the pending flag.
  - A new `pwm_update` while pending overwrites the pending values. Only one `pwm_done` is produced, for the last request.
- State IDLE (`pwm_enable`=0):
  - `pwm_out`=0; prescaler and period counter held at 0.
  - A request is applied in the cycle after capture, with no dead-time. `dir_out` updates and `pwm_done` pulses.
  - Entering RUN occurs on `pwm_enable`=1; the new period starts at count 0.
- State RUN, at a period boundary with pending=1:
  - If the pending direction equals `dir_out`: load the active ratio, clear pending, pulse `pwm_done`.
  - If it differs: go to DEAD, load the dead counter with DEAD_PERIODS, and keep pending set.
- State DEAD:
  - `pwm_out`=0; `dir_out` unchanged; the dead counter decrements at each boundary.
  - When the counter reaches 0 at a boundary: load the latest pending ratio and direction, clear pending, pulse `pwm_done`, return to RUN.
  - If the latest pending direction by then equals the old `dir_out`, it is applied the same way with no extra delay.
- `pwm_enable` falling in RUN or DEAD:
  - go to IDLE next cycle; `pwm_out`=0.
  - A still-pending request is applied immediately under the IDLE rule.
- `busy` = pending flag OR state==DEAD.

## Timing
- `pwm_out` and `dir_out` are registered. A change of ratio is visible at count 0 of the period following the boundary.
- `pwm_done` is a single-cycle pulse, asserted the same cycle the new active values first drive the pins.
- Latency in IDLE: `pwm_update` at cycle N gives `pwm_done` at N+1.
- Latency in RUN, same direction: at most 255·PRESCALE+1 cycles.
- Latency in RUN, reversed direction: at most (DEAD_PERIODS+1)·255·PRESCALE+1 cycles.
- `pwm_update` coincident with a boundary: the request is captured first and applied at that boundary.
- Reset asserted mid-period or mid-dead-time: everything returns to reset values immediately. No `pwm_done` is generated.

## Structure
- A shared package holds:
  - the state encoding (IDLE, RUN, DEAD);
  - the constant PWM_PERIOD_MAX = 254.
- Sub-module `pwm_tick_gen`: the prescaler plus period counter, producing `tick`, `period_cnt` and `boundary`.
- The state machine, request buffer and pin drivers stay in `pwm_driver`.

## Test plan
- Disabled, `pwm_update` with ratio 0x80, dir 1 at cycle 10 → `pwm_done` at cycle 11; `dir_out`=1; `pwm_out`=0.
- Enabled, PRESCALE=4, ratio 64, same direction → `pwm_done` at the next boundary. Each following period has `pwm_out` high for 256 clocks and low for 764 clocks.
- Ratio 0 and ratio 255 → `pwm_out` is constant 0 and constant 1 respectively across 3 periods.
- Running dir 0, request ratio 100 dir 1 → `pwm_out` low for exactly 2 periods, then `dir_out`=1 and `pwm_done` at the second boundary. No overlap of `pwm_out`=1 with the direction change.
- Three back-to-back updates within one period (ratios 10, 20, 30) → exactly one `pwm_done`; ratio 30 is applied.
- Reset pulse during DEAD; `pwm_enable` dropped during a pending reversal → all outputs 0 with no `pwm_done`. After the enable drop, the pending request is applied within 1 cycle, with a `pwm_done` pulse.
